// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: registered PC with trap/redirect/stall
// priority, valid/ready fetch handshake, return-address stack and BOOT/RUN/HALT control.
module pc_gen #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     INST_BYTES   = 4,
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            pc_write,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            halt_req,
  input  logic            fetch_ready,
  output logic            fetch_valid,
  output logic [XLEN-1:0] current_pc,
  input  logic            ras_push,
  input  logic [XLEN-1:0] ras_push_addr,
  input  logic            ras_pop,
  output logic            ras_empty,
  output logic            halted
);

  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [PTR_W-1:0]  ras_top_q, ras_top_d;
  logic [CNT_W-1:0]  ras_cnt_q, ras_cnt_d;
  logic [XLEN-1:0]   ras_mem_q [RAS_DEPTH];
  logic [XLEN-1:0]   ras_mem_d [RAS_DEPTH];

  logic              adv;
  logic              trap_eff;
  logic              redirect_eff;
  logic              ras_has;
  logic              ras_full;
  logic              pop_eff;
  logic [PTR_W-1:0]  push_ptr;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= BOOT;
      pc_q      <= RESET_VECTOR;
      ras_top_q <= '0;
      ras_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ras_top_q <= ras_top_d;
      ras_cnt_q <= ras_cnt_d;
    end
  end

  // Entry contents are don't-care after reset, so the storage carries no reset.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
      ras_mem_q[i] <= ras_mem_d[i];
    end
  end

  // Next-state, next-PC and RAS update
  always_comb begin
    adv          = (state_q == RUN) && fetch_ready && pc_write;
    trap_eff     = trap_valid && (state_q != BOOT);
    redirect_eff = redirect_valid && (state_q != BOOT);
    ras_has      = (ras_cnt_q != '0);
    ras_full     = (ras_cnt_q == CNT_W'(RAS_DEPTH));
    pop_eff      = adv && ras_pop && ras_has && !trap_eff && !redirect_eff;
    push_ptr     = ras_top_q + PTR_W'(1);

    state_d = state_q;
    unique case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (!trap_eff && !redirect_eff && halt_req) state_d = HALT;
      HALT:    if (trap_eff || redirect_eff) state_d = RUN;
      default: state_d = BOOT;
    endcase

    if (trap_eff)            pc_d = trap_vector;
    else if (redirect_eff)   pc_d = redirect_pc;
    else if (pop_eff)        pc_d = ras_mem_q[ras_top_q];
    else if (adv)            pc_d = pc_q + XLEN'(INST_BYTES);
    else                     pc_d = pc_q;

    ras_top_d = ras_top_q;
    ras_cnt_d = ras_cnt_q;
    for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
      ras_mem_d[i] = ras_mem_q[i];
    end
    // Push+pop in one cycle rewrites the top in place; a full push overwrites the oldest slot.
    if (trap_eff) begin
      ras_cnt_d = '0;
    end else if (ras_push && pop_eff) begin
      ras_mem_d[ras_top_q] = ras_push_addr;
    end else if (ras_push) begin
      ras_top_d           = push_ptr;
      ras_mem_d[push_ptr] = ras_push_addr;
      if (!ras_full) ras_cnt_d = ras_cnt_q + CNT_W'(1);
    end else if (pop_eff) begin
      ras_top_d = ras_top_q - PTR_W'(1);
      ras_cnt_d = ras_cnt_q - CNT_W'(1);
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    fetch_valid = (state_q == RUN);
    halted      = (state_q == HALT);
    current_pc  = pc_q;
    ras_empty   = (ras_cnt_q == '0);
  end

endmodule
